// File: rtl/artyz7_button_reader_pkg.sv
// Shared types, constants and width helper for the Arty Z7 button reader.
package artyz7_button_reader_pkg;

  typedef enum logic {
    EV_RELEASE = 1'b0,
    EV_PRESS   = 1'b1
  } event_kind_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } fsm_state_e;

  // 1 ms at 125 MHz for hardware, and a short value for simulation.
  localparam int DEBOUNCE_CYCLES_125MHZ = 125000;
  localparam int DEBOUNCE_CYCLES_SIM    = 4;

  // ceil(log2(n)), never below 1 so a 1-entry range still gets a bit.
  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/artyz7_debounce_channel.sv
// One button channel: synchronizer chain, stability counter, debounced level
// and single-cycle press/release pulses aligned with the level change.
module artyz7_debounce_channel
  import artyz7_button_reader_pkg::*;
#(
  parameter int debounce_cycles = DEBOUNCE_CYCLES_125MHZ,
  parameter int sync_stages     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W    = clog2w(debounce_cycles);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles - 1);

  logic [sync_stages-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   synced;

  assign synced = sync_q[sync_stages-1];

  always_comb begin
    sync_d    = {sync_q[sync_stages-2:0], pad_in};
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Disagreement has persisted long enough: accept the new level.
      stable_d  = synced;
      cnt_d     = '0;
      press_d   = synced;
      release_d = ~synced;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/artyz7_button_reader.sv
// Debounced button reader: per-channel level and edge pulses, plus a pending
// event store drained one event at a time over a valid/ready interface.
module artyz7_button_reader
  import artyz7_button_reader_pkg::*;
#(
  parameter int num_buttons     = 4,
  parameter int debounce_cycles = DEBOUNCE_CYCLES_125MHZ,
  parameter int sync_stages     = 2
) (
  input  logic                            ext_clk,
  input  logic                            ext_reset_n,
  input  logic [num_buttons-1:0]          button_in,
  output logic [num_buttons-1:0]          button_level,
  output logic [num_buttons-1:0]          press_pulse,
  output logic [num_buttons-1:0]          release_pulse,
  output logic                            event_valid,
  input  logic                            event_ready,
  output logic [clog2w(num_buttons)-1:0]  event_index,
  output logic                            event_is_press,
  output logic                            overflow
);

  localparam int IDX_W = clog2w(num_buttons);

  logic [num_buttons-1:0] pend_press_q, pend_press_d;
  logic [num_buttons-1:0] pend_release_q, pend_release_d;
  logic [num_buttons-1:0] clr_press, clr_release;
  logic [num_buttons-1:0] cand_press, cand_release;
  fsm_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  event_kind_e            kind_q, kind_d;
  logic                   accept;
  logic                   found;
  logic [IDX_W-1:0]       sel_idx;
  event_kind_e            sel_kind;

  for (genvar g = 0; g < num_buttons; g++) begin : gen_ch
    artyz7_debounce_channel #(
      .debounce_cycles (debounce_cycles),
      .sync_stages     (sync_stages)
    ) u_ch (
      .clk           (ext_clk),
      .rst_n         (ext_reset_n),
      .pad_in        (button_in[g]),
      .level         (button_level[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g])
    );
  end

  assign accept = (state_q == ST_PRESENT) && event_ready;

  // Pending bits: a new pulse wins over a simultaneous acceptance.
  always_comb begin
    clr_press   = '0;
    clr_release = '0;
    if (accept) begin
      if (kind_q == EV_PRESS) clr_press[idx_q]   = 1'b1;
      else                    clr_release[idx_q] = 1'b1;
    end
    cand_press     = pend_press_q | press_pulse;
    cand_release   = pend_release_q | release_pulse;
    pend_press_d   = press_pulse | (pend_press_q & ~clr_press);
    pend_release_d = release_pulse | (pend_release_q & ~clr_release);
    overflow       = (|(press_pulse & pend_press_q & ~clr_press)) ||
                     (|(release_pulse & pend_release_q & ~clr_release));
  end

  // Lowest channel wins; with both kinds pending, the one opposite to the
  // current level happened first.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    sel_kind = EV_RELEASE;
    for (int i = num_buttons - 1; i >= 0; i--) begin
      if (cand_press[i] || cand_release[i]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(i);
        if (cand_press[i] && cand_release[i])
          sel_kind = button_level[i] ? EV_RELEASE : EV_PRESS;
        else
          sel_kind = cand_press[i] ? EV_PRESS : EV_RELEASE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kind_d  = kind_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_PRESENT;
          idx_d   = sel_idx;
          kind_d  = sel_kind;
        end
      end
      ST_PRESENT: begin
        if (event_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ext_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      pend_press_q   <= '0;
      pend_release_q <= '0;
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      kind_q         <= EV_RELEASE;
    end else begin
      pend_press_q   <= pend_press_d;
      pend_release_q <= pend_release_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      kind_q         <= kind_d;
    end
  end

  assign event_valid    = (state_q == ST_PRESENT);
  assign event_index    = idx_q;
  assign event_is_press = (kind_q == EV_PRESS);

endmodule

// File: tb/tb_artyz7_button_reader.sv
// Bench for artyz7_button_reader: directed scenarios plus randomized traffic
// compared against a window-based debounce and event-queue reference model.
module tb_artyz7_button_reader;

  localparam int NB = 4;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int HL = S + D;

  logic          ext_clk     = 1'b0;
  logic          ext_reset_n = 1'b1;
  logic [NB-1:0] button_in   = '0;
  logic          event_ready = 1'b0;
  logic [NB-1:0] button_level, press_pulse, release_pulse;
  logic          event_valid, event_is_press, overflow;
  logic [1:0]    event_index;

  int n_vec = 0;
  int n_err = 0;

  always #5 ext_clk = ~ext_clk;

  artyz7_button_reader #(
    .num_buttons     (NB),
    .debounce_cycles (D),
    .sync_stages     (S)
  ) dut (
    .ext_clk        (ext_clk),
    .ext_reset_n    (ext_reset_n),
    .button_in      (button_in),
    .button_level   (button_level),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_index    (event_index),
    .event_is_press (event_is_press),
    .overflow       (overflow)
  );

  // Reference model: hist[c][0] is the newest pad sample. A level changes to v
  // when the D samples older than the S newest all equal v.
  bit            hist [NB][HL];
  logic [NB-1:0] m_level, m_pp, m_rp, m_pend_p, m_pend_r;
  bit            m_valid, m_press;
  int            m_idx;
  int            obs[$];

  task automatic model_reset();
    for (int c = 0; c < NB; c++)
      for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
    m_level = '0; m_pp = '0; m_rp = '0; m_pend_p = '0; m_pend_r = '0;
    m_valid = 1'b0; m_press = 1'b0; m_idx = 0;
  endtask

  function automatic logic [NB-1:0] clr_vec(input bit press);
    logic [NB-1:0] v;
    v = '0;
    if (m_valid && event_ready && (m_press == press)) v[m_idx] = 1'b1;
    return v;
  endfunction

  function automatic bit model_ovf();
    return (|(m_pp & m_pend_p & ~clr_vec(1'b1))) || (|(m_rp & m_pend_r & ~clr_vec(1'b0)));
  endfunction

  task automatic tick();
    logic [NB-1:0] s, lvl_n, cp, cr, cand_p, cand_r, pend_p_n, pend_r_n;
    bit            hist_n [NB][HL];
    bit            all1, all0, v_n, prs_n, found;
    int            idx_n;
    s = button_in;
    if (event_valid && event_ready) obs.push_back(int'(event_index) * 2 + int'(event_is_press));
    cp = clr_vec(1'b1);
    cr = clr_vec(1'b0);
    cand_p = m_pend_p | m_pp;
    cand_r = m_pend_r | m_rp;
    pend_p_n = m_pp | (m_pend_p & ~cp);
    pend_r_n = m_rp | (m_pend_r & ~cr);
    for (int c = 0; c < NB; c++) begin
      hist_n[c][0] = s[c];
      for (int j = 1; j < HL; j++) hist_n[c][j] = hist[c][j-1];
      all1 = 1'b1; all0 = 1'b1;
      for (int j = S; j < HL; j++) begin
        if (hist_n[c][j]) all0 = 1'b0;
        else              all1 = 1'b0;
      end
      lvl_n[c] = all1 ? 1'b1 : (all0 ? 1'b0 : m_level[c]);
    end
    v_n = 1'b0; idx_n = m_idx; prs_n = m_press; found = 1'b0;
    if (m_valid) begin
      v_n = !event_ready;
    end else begin
      for (int c = 0; c < NB; c++) begin
        if (!found && (cand_p[c] || cand_r[c])) begin
          found = 1'b1; v_n = 1'b1; idx_n = c;
          prs_n = (cand_p[c] && cand_r[c]) ? !m_level[c] : cand_p[c];
        end
      end
    end
    @(posedge ext_clk);
    #1;
    if (!ext_reset_n) begin
      model_reset();
    end else begin
      hist     = hist_n;
      m_pp     = lvl_n & ~m_level;
      m_rp     = ~lvl_n & m_level;
      m_level  = lvl_n;
      m_pend_p = pend_p_n;
      m_pend_r = pend_r_n;
      m_valid  = v_n;
      m_idx    = idx_n;
      m_press  = prs_n;
    end
  endtask

  task automatic test_reset();
    #1;
    ext_reset_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({button_level, press_pulse, release_pulse} !== '0) begin
      n_err++; $display("FAIL reset_levels got %b want 0", {button_level, press_pulse, release_pulse});
    end
    n_vec++;
    if ({event_valid, event_index, event_is_press, overflow} !== 5'b0) begin
      n_err++; $display("FAIL reset_event got %b want 0", {event_valid, event_index, event_is_press, overflow});
    end
    tick(); tick();
    n_vec++;
    if ({button_level, event_valid, overflow} !== '0) begin
      n_err++; $display("FAIL reset_clocked got %b want 0", {button_level, event_valid, overflow});
    end
    ext_reset_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int lat;
    lat = 0;
    button_in[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (button_level[1] === 1'b1) begin lat = e; break; end
    end
    n_vec++;
    if (lat != S + D) begin n_err++; $display("FAIL press_latency got %0d want %0d", lat, S + D); end
    n_vec++;
    if (press_pulse !== 4'b0010 || release_pulse !== 4'b0000) begin
      n_err++; $display("FAIL press_pulse got %b/%b want 0010/0000", press_pulse, release_pulse);
    end
    tick();
    n_vec++;
    if (press_pulse !== 4'b0000 || button_level !== 4'b0010) begin
      n_err++; $display("FAIL press_width got pulse %b level %b want 0000 0010", press_pulse, button_level);
    end
    n_vec++;
    if (event_valid !== 1'b1 || event_index !== 2'd1 || event_is_press !== 1'b1) begin
      n_err++; $display("FAIL press_event got v%b i%0d p%b want v1 i1 p1", event_valid, event_index, event_is_press);
    end
    event_ready = 1'b1; tick(); event_ready = 1'b0;
    n_vec++;
    if (event_valid !== 1'b0) begin n_err++; $display("FAIL press_accept got valid %b want 0", event_valid); end
  endtask

  task automatic test_glitch();
    button_in[0] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) button_in[0] = 1'b0;
      tick();
      n_vec++;
      if (button_level[0] !== 1'b0 || press_pulse[0] !== 1'b0 || release_pulse[0] !== 1'b0 || event_valid !== 1'b0) begin
        n_err++;
        $display("FAIL glitch cycle %0d got lvl%b pp%b rp%b v%b want all 0", c, button_level[0], press_pulse[0], release_pulse[0], event_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    w = 0;
    event_ready = 1'b0;
    button_in[3:2] = 2'b11;
    while (event_valid !== 1'b1 && w < 20) begin tick(); w++; end
    n_vec++;
    if (event_valid !== 1'b1) begin n_err++; $display("FAIL b2b_timeout got valid %b want 1", event_valid); end
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (event_valid !== 1'b1 || event_index !== 2'd2 || event_is_press !== 1'b1) begin
        n_err++; $display("FAIL b2b_hold cycle %0d got v%b i%0d p%b want v1 i2 p1", k, event_valid, event_index, event_is_press);
      end
      tick();
    end
    event_ready = 1'b1;
    tick();
    n_vec++;
    if (event_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap got valid %b want 0", event_valid); end
    tick();
    n_vec++;
    if (event_valid !== 1'b1 || event_index !== 2'd3 || event_is_press !== 1'b1) begin
      n_err++; $display("FAIL b2b_second got v%b i%0d p%b want v1 i3 p1", event_valid, event_index, event_is_press);
    end
    tick();
    event_ready = 1'b0;
    n_vec++;
    if (event_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained got valid %b want 0", event_valid); end
  endtask

  task automatic test_overflow();
    int novf;
    novf = 0;
    event_ready = 1'b0;
    obs.delete();
    for (int ph = 0; ph < 3; ph++) begin
      button_in[0] = (ph != 1);
      for (int k = 0; k < 9; k++) begin
        tick();
        n_vec++;
        if (overflow !== model_ovf()) begin
          n_err++; $display("FAIL ovf_cycle phase %0d got %b want %b", ph, overflow, model_ovf());
        end
        if (overflow === 1'b1) novf++;
      end
    end
    n_vec++;
    if (novf != 1) begin n_err++; $display("FAIL ovf_count got %0d want 1", novf); end
    event_ready = 1'b1;
    repeat (8) tick();
    event_ready = 1'b0;
    n_vec++;
    if (obs.size() != 2 || obs[0] != 1 || obs[1] != 0) begin
      n_err++; $display("FAIL ovf_drain got size %0d first %0d second %0d want 2 1 0", obs.size(),
                        (obs.size() > 0) ? obs[0] : -1, (obs.size() > 1) ? obs[1] : -1);
    end
  endtask

  task automatic test_same_cycle();
    int w;
    w = 0;
    event_ready = 1'b0;
    button_in[1] = 1'b0;
    repeat (8) tick();
    event_ready = 1'b1;
    repeat (3) tick();
    event_ready = 1'b0;
    obs.delete();
    button_in[1] = 1'b1;
    repeat (8) tick();
    button_in[1] = 1'b0;
    repeat (8) tick();
    button_in[1] = 1'b1;
    while (press_pulse[1] !== 1'b1 && w < 12) begin tick(); w++; end
    n_vec++;
    if (press_pulse[1] !== 1'b1) begin n_err++; $display("FAIL sc_pulse got %b want 1", press_pulse[1]); end
    n_vec++;
    if (event_valid !== 1'b1 || event_index !== 2'd1 || event_is_press !== 1'b1) begin
      n_err++; $display("FAIL sc_presented got v%b i%0d p%b want v1 i1 p1", event_valid, event_index, event_is_press);
    end
    event_ready = 1'b1;
    #1;
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL sc_overflow got %b want 0", overflow); end
    repeat (6) tick();
    event_ready = 1'b0;
    n_vec++;
    if (obs.size() != 3 || obs[0] != 3 || obs[1] != 2 || obs[2] != 3) begin
      n_err++; $display("FAIL sc_sequence got size %0d [%0d %0d %0d] want 3 [3 2 3]", obs.size(),
                        (obs.size() > 0) ? obs[0] : -1, (obs.size() > 1) ? obs[1] : -1, (obs.size() > 2) ? obs[2] : -1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int ch;
        ch = $urandom_range(0, NB - 1);
        button_in[ch] = ~button_in[ch];
      end
      event_ready = ($urandom_range(0, 2) != 0);
      tick();
      n_vec++;
      if ({button_level, press_pulse, release_pulse} !== {m_level, m_pp, m_rp}) begin
        n_err++; $display("FAIL rnd_debounce cycle %0d got %b want %b", c,
                          {button_level, press_pulse, release_pulse}, {m_level, m_pp, m_rp});
      end
      n_vec++;
      if (event_valid !== m_valid || (m_valid && (event_index !== m_idx[1:0] || event_is_press !== m_press))) begin
        n_err++; $display("FAIL rnd_event cycle %0d got v%b i%0d p%b want v%b i%0d p%b", c,
                          event_valid, event_index, event_is_press, m_valid, m_idx, m_press);
      end
      n_vec++;
      if (overflow !== model_ovf()) begin
        n_err++; $display("FAIL rnd_overflow cycle %0d got %b want %b", c, overflow, model_ovf());
      end
    end
  endtask

  task automatic test_async_reset();
    int lat;
    lat = 0;
    event_ready = 1'b1;
    button_in = '1;
    repeat (20) tick();
    event_ready = 1'b0;
    button_in = '0;
    repeat (9) tick();
    n_vec++;
    if (event_valid !== 1'b1) begin n_err++; $display("FAIL ar_present got valid %b want 1", event_valid); end
    #3;
    ext_reset_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (event_valid !== 1'b0 || button_level !== 4'b0000) begin
      n_err++; $display("FAIL ar_immediate got v%b lvl %b want v0 0000", event_valid, button_level);
    end
    button_in = 4'b0100;
    tick(); tick();
    ext_reset_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (press_pulse[2] === 1'b1) begin lat = e; break; end
    end
    n_vec++;
    if (lat != S + D) begin n_err++; $display("FAIL ar_latency got %0d want %0d", lat, S + D); end
    n_vec++;
    if (button_level !== 4'b0100) begin n_err++; $display("FAIL ar_level got %b want 0100", button_level); end
    tick();
    n_vec++;
    if (event_valid !== 1'b1 || event_index !== 2'd2 || event_is_press !== 1'b1) begin
      n_err++; $display("FAIL ar_event got v%b i%0d p%b want v1 i2 p1", event_valid, event_index, event_is_press);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_back_to_back();
    test_overflow();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
